icache_set_assoc: RTL and testbench

//  N-way set-associative instruction cache between RV32I fetch stage and block memory.

---
 rtl/icache_pkg.sv | 25 ++
 rtl/icache_way.sv | 58 +++++
 rtl/icache_set_assoc.sv | 186 ++++++++++++++++++
 tb/tb_icache_set_assoc.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and default geometry for the set-associative instruction cache.
// Refill controller states plus field-width helpers for the default configuration.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } state_e;

  localparam int DEF_BLOCK_SIZE = 32;
  localparam int DEF_NUM_SETS   = 128;
  localparam int DEF_NUM_WAYS   = 2;

  // A single way still needs a one-bit pointer so the vectors stay legal.
  function automatic int way_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int OFFSET_WIDTH = $clog2(DEF_BLOCK_SIZE);
  localparam int INDEX_WIDTH  = $clog2(DEF_NUM_SETS);
  localparam int TAG_WIDTH    = 32 - OFFSET_WIDTH - INDEX_WIDTH;
  localparam int WAY_WIDTH    = way_bits(DEF_NUM_WAYS);

endpackage

// File: rtl/icache_way.sv
// One cache way: tag/data/valid per set, single refill write port, flash clear.
// Lookup is combinational (hit and selected word in the same cycle); writes land on posedge.
module icache_way
  import icache_pkg::*;
#(
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int NUM_SETS   = DEF_NUM_SETS,
  parameter int OFF_W      = OFFSET_WIDTH,
  parameter int IDX_W      = INDEX_WIDTH,
  parameter int TAG_W      = TAG_WIDTH,
  parameter int WSEL_W     = (OFF_W > 2) ? OFF_W - 2 : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_all_i,
  input  logic                    wr_en_i,
  input  logic [IDX_W-1:0]        wr_idx_i,
  input  logic [TAG_W-1:0]        wr_tag_i,
  input  logic [BLOCK_SIZE*8-1:0] wr_line_i,
  output logic                    wr_line_vld_o,
  input  logic [IDX_W-1:0]        rd_idx_i,
  input  logic [TAG_W-1:0]        rd_tag_i,
  input  logic [WSEL_W-1:0]       rd_word_i,
  output logic                    hit_o,
  output logic [31:0]             word_o
);

  localparam int LINE_W = BLOCK_SIZE * 8;

  logic [TAG_W-1:0]  tag_q  [NUM_SETS];
  logic [LINE_W-1:0] data_q [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q;
  logic [LINE_W-1:0] rd_line;

  // Payload arrays carry no reset; only the valid bits decide whether a line exists.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_line_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (clear_all_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  assign rd_line       = data_q[rd_idx_i];
  assign hit_o         = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign word_o        = rd_line[32*rd_word_i +: 32];
  assign wr_line_vld_o = valid_q[wr_idx_i];

endmodule

// File: rtl/icache_set_assoc.sv
// N-way set-associative I-cache: 1-cycle hit, blocking single-block refill (IDLE/REQ/WAIT), fence.i flush.
// Memory stalls via memBusy hold WAIT; define ICACHE_PERF_EN to add hitCount/missCount.
module icache_set_assoc
  import icache_pkg::*;
#(
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int NUM_SETS   = DEF_NUM_SETS,
  parameter int NUM_WAYS   = DEF_NUM_WAYS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             address,
  input  logic                    flush,
  output logic [31:0]             instruction,
  output logic                    valid,
  input  logic [BLOCK_SIZE*8-1:0] memReadData,
  input  logic                    memBusy,
  output logic [31:0]             memAddress,
  output logic                    memRead
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]             hitCount,
  output logic [31:0]             missCount
`endif
);

  localparam int OFF_W  = $clog2(BLOCK_SIZE);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int WAY_W  = way_bits(NUM_WAYS);
  localparam int WSEL_W = (OFF_W > 2) ? OFF_W - 2 : 1;

  state_e            state_q, state_d;
  logic [31:0]       miss_addr_q, miss_addr_d;
  logic              abort_q, abort_d;
  logic [WAY_W-1:0]  rr_q [NUM_SETS];

  logic [IDX_W-1:0]  lk_idx, miss_idx;
  logic [TAG_W-1:0]  lk_tag, miss_tag;
  logic [WSEL_W-1:0] lk_word;
  logic [NUM_WAYS-1:0] hit_w, vld_w;
  logic [31:0]       word_w [NUM_WAYS];
  logic              hit_any;
  logic [31:0]       hit_word;
  logic [WAY_W-1:0]  victim, rr_next;
  logic              fill_en, miss_start;
  logic              unused_bits;

  assign lk_idx   = address[OFF_W +: IDX_W];
  assign lk_tag   = address[31 -: TAG_W];
  assign miss_idx = miss_addr_q[OFF_W +: IDX_W];
  assign miss_tag = miss_addr_q[31 -: TAG_W];
  assign unused_bits = ^{address[1:0], miss_addr_q[OFF_W-1:0]};

  generate
    if (OFF_W > 2) begin : g_wsel
      assign lk_word = address[OFF_W-1:2];
    end else begin : g_wsel_one
      assign lk_word = '0;
    end

    for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
      icache_way #(
        .BLOCK_SIZE(BLOCK_SIZE),
        .NUM_SETS  (NUM_SETS),
        .OFF_W     (OFF_W),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W),
        .WSEL_W    (WSEL_W)
      ) u_way (
        .clk          (clk),
        .rst          (rst),
        .clear_all_i  (flush),
        .wr_en_i      (fill_en && (victim == WAY_W'(g))),
        .wr_idx_i     (miss_idx),
        .wr_tag_i     (miss_tag),
        .wr_line_i    (memReadData),
        .wr_line_vld_o(vld_w[g]),
        .rd_idx_i     (lk_idx),
        .rd_tag_i     (lk_tag),
        .rd_word_i    (lk_word),
        .hit_o        (hit_w[g]),
        .word_o       (word_w[g])
      );
    end
  endgenerate

  // Ways hit one-hot, so OR-ing the gated words is an exact mux.
  always_comb begin
    hit_any  = |hit_w;
    hit_word = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (hit_w[w]) hit_word = hit_word | word_w[w];
    end
  end

  // Lowest-numbered invalid way wins; otherwise fall back to the set's round-robin pointer.
  always_comb begin
    victim = rr_q[miss_idx];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!vld_w[w]) victim = WAY_W'(w);
    end
    rr_next = (rr_q[miss_idx] == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_q[miss_idx] + WAY_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    abort_d     = abort_q;
    valid       = 1'b0;
    instruction = '0;
    memRead     = 1'b0;
    memAddress  = '0;
    fill_en     = 1'b0;
    miss_start  = 1'b0;
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (flush) begin
          state_d = IDLE;
        end else if (hit_any) begin
          valid       = 1'b1;
          instruction = hit_word;
        end else begin
          miss_start  = 1'b1;
          miss_addr_d = {address[31:OFF_W], OFF_W'(0)};
          state_d     = REQ;
        end
      end
      REQ: begin
        memRead    = 1'b1;
        memAddress = miss_addr_q;
        if (flush) abort_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        memAddress = miss_addr_q;
        if (flush) abort_d = 1'b1;
        if (memBusy) begin
          memRead = 1'b1;
        end else begin
          // A flush landing on the fill cycle itself must also suppress the write.
          fill_en = !abort_q && !flush;
          abort_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      abort_q     <= 1'b0;
      for (int i = 0; i < NUM_SETS; i++) rr_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      abort_q     <= abort_d;
      if (fill_en) rr_q[miss_idx] <= rr_next;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (flush) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (valid)      hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_start) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hitCount  = hit_cnt_q;
  assign missCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_set_assoc.sv
// Directed bench for icache_set_assoc (default geometry: 2 ways, 32B lines, 128 sets).
// Memory returns word (addr ^ salt) for every word-aligned byte address.
module tb_icache_set_assoc;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  address = 32'h0;
  logic         flush = 1'b0;
  logic [31:0]  instruction;
  logic         valid;
  logic [255:0] memReadData;
  logic         memBusy = 1'b1;
  logic [31:0]  memAddress;
  logic         memRead;
`ifdef ICACHE_PERF_EN
  logic [31:0]  hit_count, miss_count;
`endif

  logic [31:0] salt = 32'h5A5A_0000;
  int tests = 0;
  int fails = 0;

  icache_set_assoc dut (
    .clk        (clk),
    .rst        (rst_n),
    .address    (address),
    .flush      (flush),
    .instruction(instruction),
    .valid      (valid),
    .memReadData(memReadData),
    .memBusy    (memBusy),
    .memAddress (memAddress),
    .memRead    (memRead)
`ifdef ICACHE_PERF_EN
    ,
    .hitCount   (hit_count),
    .missCount  (miss_count)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    memReadData = '0;
    for (int w = 0; w < 8; w++)
      memReadData[32*w +: 32] = ({memAddress[31:5], 5'b0} + 32'(w * 4)) ^ salt;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    memBusy = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Runs a full miss for address a in IDLE: REQ, nbusy busy WAIT cycles, then fill.
  task automatic fill(input logic [31:0] a, input int nbusy);
    address = a;
    flush = 1'b0;
    memBusy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    repeat (nbusy) begin
      @(posedge clk); #1;
    end
    memBusy = 1'b0;
    @(posedge clk); #1;
    memBusy = 1'b1;
  endtask

  task automatic probe(input logic [31:0] a, output logic v, output logic [31:0] ins);
    address = a;
    memBusy = 1'b1;
    flush = 1'b0;
    #1;
    v = valid;
    ins = instruction;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    address = 32'h0000_0100;
    @(posedge clk); #1;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid); end
    tests++; if (memRead !== 1'b0) begin fails++; $display("FAIL reset_memRead got %b want 0", memRead); end
    tests++; if (memAddress !== 32'h0) begin fails++; $display("FAIL reset_memAddress got %h want 0", memAddress); end
    tests++; if (instruction !== 32'h0) begin fails++; $display("FAIL reset_instruction got %h want 0", instruction); end
`ifdef ICACHE_PERF_EN
    tests++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      fails++; $display("FAIL reset_counters got %0d/%0d want 0/0", hit_count, miss_count);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_cold_miss();
    int rd;
    do_reset();
    salt = 32'h5A5A_0000;
    address = 32'h0000_0100;
    #1;
    tests++; if (valid !== 1'b0 || memRead !== 1'b0) begin
      fails++; $display("FAIL cold_lookup got valid=%b memRead=%b want 0/0", valid, memRead);
    end
    @(posedge clk); #1;
    tests++; if (memRead !== 1'b1 || memAddress !== 32'h0000_0100) begin
      fails++; $display("FAIL cold_req got memRead=%b addr=%h want 1/00000100", memRead, memAddress);
    end
    rd = (memRead === 1'b1) ? 1 : 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (memRead === 1'b1) rd++;
      tests++; if (valid !== 1'b0) begin fails++; $display("FAIL cold_wait_valid got %b want 0", valid); end
    end
    @(posedge clk); #1;
    memBusy = 1'b0;
    #1;
    tests++; if (memRead !== 1'b0) begin fails++; $display("FAIL cold_fill_memRead got %b want 0", memRead); end
    tests++; if (rd !== 4) begin fails++; $display("FAIL cold_memRead_cycles got %0d want 4", rd); end
    @(posedge clk); #1;
    memBusy = 1'b1;
    #1;
    tests++; if (valid !== 1'b1 || instruction !== (32'h0000_0100 ^ salt)) begin
      fails++; $display("FAIL cold_first_hit got valid=%b ins=%h want 1/%h", valid, instruction, 32'h0000_0100 ^ salt);
    end
    address = 32'h0000_0104;
    #1;
    tests++; if (valid !== 1'b1 || instruction !== (32'h0000_0104 ^ salt)) begin
      fails++; $display("FAIL cold_word1 got valid=%b ins=%h want 1/%h", valid, instruction, 32'h0000_0104 ^ salt);
    end
  endtask

  task automatic test_round_robin();
    logic v;
    logic [31:0] ins;
    do_reset();
    salt = 32'hC0DE_0000;
    fill(32'h0000_0000, 1);
    fill(32'h0000_1000, 1);
    probe(32'h0000_0000, v, ins);
    tests++; if (v !== 1'b1 || ins !== (32'h0000_0000 ^ salt)) begin
      fails++; $display("FAIL rr_hit0 got valid=%b ins=%h want 1/%h", v, ins, 32'h0000_0000 ^ salt);
    end
    probe(32'h0000_101C, v, ins);
    tests++; if (v !== 1'b1 || ins !== (32'h0000_101C ^ salt)) begin
      fails++; $display("FAIL rr_hit1 got valid=%b ins=%h want 1/%h", v, ins, 32'h0000_101C ^ salt);
    end
    fill(32'h0000_2000, 0);
    probe(32'h0000_2008, v, ins);
    tests++; if (v !== 1'b1 || ins !== (32'h0000_2008 ^ salt)) begin
      fails++; $display("FAIL rr_hit2 got valid=%b ins=%h want 1/%h", v, ins, 32'h0000_2008 ^ salt);
    end
    probe(32'h0000_1000, v, ins);
    tests++; if (v !== 1'b1 || ins !== (32'h0000_1000 ^ salt)) begin
      fails++; $display("FAIL rr_keep_1000 got valid=%b ins=%h want 1/%h", v, ins, 32'h0000_1000 ^ salt);
    end
    probe(32'h0000_0000, v, ins);
    tests++; if (v !== 1'b0) begin fails++; $display("FAIL rr_evict_0000 got valid=%b want 0", v); end
  endtask

  task automatic test_flush_wait();
    logic v;
    logic [31:0] ins;
    do_reset();
    salt = 32'h1234_0000;
    fill(32'h0000_0100, 0);
    address = 32'h0000_0200;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    memBusy = 1'b0;
    #1;
    tests++; if (memRead !== 1'b0 || memAddress !== 32'h0000_0200) begin
      fails++; $display("FAIL flush_handshake got memRead=%b addr=%h want 0/00000200", memRead, memAddress);
    end
    @(posedge clk); #1;
    probe(32'h0000_0200, v, ins);
    tests++; if (v !== 1'b0) begin fails++; $display("FAIL flush_no_write got valid=%b want 0", v); end
    @(posedge clk); #1;
    tests++; if (memRead !== 1'b1 || memAddress !== 32'h0000_0200) begin
      fails++; $display("FAIL flush_remiss got memRead=%b addr=%h want 1/00000200", memRead, memAddress);
    end
    @(posedge clk); #1;
    memBusy = 1'b0;
    @(posedge clk); #1;
    probe(32'h0000_0100, v, ins);
    tests++; if (v !== 1'b0) begin fails++; $display("FAIL flush_prior_line got valid=%b want 0", v); end
    fill(32'h0000_0100, 0);
    probe(32'h0000_0204, v, ins);
    tests++; if (v !== 1'b1 || ins !== (32'h0000_0204 ^ salt)) begin
      fails++; $display("FAIL flush_refilled got valid=%b ins=%h want 1/%h", v, ins, 32'h0000_0204 ^ salt);
    end
    flush = 1'b1;
    #1;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL idle_flush_valid got %b want 0", valid); end
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL idle_flush_cleared got %b want 0", valid); end
  endtask

  task automatic test_addr_change();
    logic v;
    logic [31:0] ins;
    do_reset();
    salt = 32'hBEEF_0000;
    address = 32'h0000_0300;
    @(posedge clk); #1;
    @(posedge clk); #1;
    address = 32'h0000_0400;
    @(posedge clk); #1;
    memBusy = 1'b0;
    #1;
    tests++; if (memAddress !== 32'h0000_0300) begin
      fails++; $display("FAIL addr_change_memAddress got %h want 00000300", memAddress);
    end
    @(posedge clk); #1;
    probe(32'h0000_0400, v, ins);
    tests++; if (v !== 1'b0) begin fails++; $display("FAIL addr_change_0400 got valid=%b want 0", v); end
    probe(32'h0000_030C, v, ins);
    tests++; if (v !== 1'b1 || ins !== (32'h0000_030C ^ salt)) begin
      fails++; $display("FAIL addr_change_0300 got valid=%b ins=%h want 1/%h", v, ins, 32'h0000_030C ^ salt);
    end
  endtask

  task automatic test_reset_mid_miss();
    logic v;
    logic [31:0] ins;
    do_reset();
    fill(32'h0000_0100, 0);
    address = 32'h0000_0500;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++; if (memRead !== 1'b1) begin fails++; $display("FAIL rst_mid_pre got memRead=%b want 1", memRead); end
    rst_n = 1'b0;
    #1;
    tests++; if (memRead !== 1'b0 || memAddress !== 32'h0 || valid !== 1'b0 || instruction !== 32'h0) begin
      fails++; $display("FAIL rst_mid_outputs got rd=%b addr=%h v=%b ins=%h want all 0", memRead, memAddress, valid, instruction);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    probe(32'h0000_0100, v, ins);
    tests++; if (v !== 1'b0) begin fails++; $display("FAIL rst_mid_prior_line got valid=%b want 0", v); end
  endtask

`ifdef ICACHE_PERF_EN
  task automatic test_perf_counters();
    do_reset();
    fill(32'h0000_0100, 0);
    for (int i = 0; i < 5; i++) begin
      address = 32'h0000_0100 + 32'(i * 4);
      @(posedge clk); #1;
    end
    tests++; if (miss_count !== 32'd1 || hit_count !== 32'd5) begin
      fails++; $display("FAIL perf_counts got miss=%0d hit=%0d want 1/5", miss_count, hit_count);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    tests++; if (miss_count !== 32'd0 || hit_count !== 32'd0) begin
      fails++; $display("FAIL perf_flush got miss=%0d hit=%0d want 0/0", miss_count, hit_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss();
    test_round_robin();
    test_flush_wait();
    test_addr_change();
    test_reset_mid_miss();
`ifdef ICACHE_PERF_EN
    test_perf_counters();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
